// File: rtl/pcie_rx_reader_pkg.sv
// rtl/pcie_rx_reader_pkg.sv - shared constants and FSM encoding for the transaction-layer egress reader
package pcie_rx_reader_pkg;

  // Word layout shared with the transaction layer's router.
  localparam int DEFAULT_DATA_W   = 6;
  localparam int DEFAULT_DEST_BIT = 4;
  localparam int DEFAULT_CNT_W    = 5;

  typedef logic [1:0] rx_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/pcie_rr_arb2.sv
// rtl/pcie_rr_arb2.sv - two-way round-robin arbiter, one grant per cycle
module pcie_rr_arb2 (
  input  logic       en,
  input  logic [1:0] req,
  input  logic       last_src,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      // On contention the requester that did not win last time goes first.
      if (req[0] && req[1]) begin
        grant = last_src ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/pcie_rx_reader.sv
// rtl/pcie_rx_reader.sv - drains D0/D1 output FIFOs round-robin into one checked, counted stream
module pcie_rx_reader
  import pcie_rx_reader_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEST_BIT = DEFAULT_DEST_BIT,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              hold,
  input  logic              active_in,
  input  logic              idle_in,
  input  logic              empty0,
  input  logic              empty1,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  output logic              pop0,
  output logic              pop1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              src_out,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              err_out,
  output logic              done_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rx_state_t         state_q, state_d;
  logic              last_src_q, last_src_d;
  logic              inflight_q, inflight_d;
  logic              src_q, src_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic              pop_en;
  logic [1:0]        grant;
  logic [DATA_W-1:0] cap_data;
  logic              cap_mismatch;

  assign pop_en = (state_q == ST_RUN) && init && !hold;

  pcie_rr_arb2 u_arb (
    .en       (pop_en),
    .req      ({~empty1, ~empty0}),
    .last_src (last_src_q),
    .grant    (grant)
  );

  assign pop0 = grant[0];
  assign pop1 = grant[1];

  // FIFO read data arrives the cycle after the pop; src_q already names its FIFO.
  assign cap_data     = src_q ? data_in1 : data_in0;
  assign cap_mismatch = (cap_data[DEST_BIT] != src_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (init) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!init) begin
          state_d = ST_IDLE;
        end else if (idle_in && empty0 && empty1 && !inflight_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!init) begin
          state_d = ST_IDLE;
        end else if (active_in || !empty0 || !empty1) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_src_d = last_src_q;
    src_d      = src_q;
    if (pop1) begin
      last_src_d = 1'b1;
      src_d      = 1'b1;
    end else if (pop0) begin
      last_src_d = 1'b0;
      src_d      = 1'b0;
    end
    inflight_d = pop0 | pop1;
    done_d     = (state_d == ST_DONE);
  end

  always_comb begin
    data_d = data_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    err_d  = err_q;
    if (inflight_q) begin
      data_d = cap_data;
      // Misrouted words are still delivered and counted; only the flag records them.
      if (cap_mismatch) err_d = 1'b1;
      if (!src_q && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_W'(1);
      if (src_q && (cnt1_q != CNT_MAX))  cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_src_q <= 1'b1;
      inflight_q <= 1'b0;
      src_q      <= 1'b0;
      data_q     <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      inflight_q <= inflight_d;
      src_q      <= src_d;
      data_q     <= data_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // During a capture cycle the word is presented straight from the FIFO read register.
  assign data_out  = inflight_q ? cap_data : data_q;
  assign valid_out = inflight_q;
  assign src_out   = src_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
  assign err_out   = err_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_pcie_rx_reader.sv
// tb/tb_pcie_rx_reader.sv - bench with FIFO models and scoreboard for pcie_rx_reader
module tb_pcie_rx_reader;

  localparam int DW = 6;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset, init, hold, active_in, idle_in;
  logic          empty0 = 1'b1, empty1 = 1'b1;
  logic [DW-1:0] data_in0 = '0, data_in1 = '0;
  logic          pop0, pop1, valid_out, src_out, err_out, done_out;
  logic [DW-1:0] data_out;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  pcie_rx_reader #(.DATA_W(DW), .DEST_BIT(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .init(init), .hold(hold),
    .active_in(active_in), .idle_in(idle_in),
    .empty0(empty0), .empty1(empty1),
    .data_in0(data_in0), .data_in1(data_in1),
    .pop0(pop0), .pop1(pop1),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .cnt0(cnt0), .cnt1(cnt1), .err_out(err_out), .done_out(done_out)
  );

  typedef struct {
    logic          sel;
    logic [DW-1:0] data;
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
    logic          err;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  int            n_deliv = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] log_q[$];
  logic          pop0_s, pop1_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  // FIFO models plus scoreboard: pops are recorded at the negedge, read data
  // appears just after the next posedge, deliveries are matched in order.
  always begin
    logic [DW:0] e;
    @(negedge clk);
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid_out), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 32'(data_out), 32'(e[DW-1:0]));
        check("sb_src", 32'(src_out), 32'(e[DW]));
      end
      log_q.push_back(data_out);
      n_deliv++;
    end
    if (pop0 === 1'b1 && empty0) check("pop0_when_empty", 32'(pop0), 32'(0));
    if (pop1 === 1'b1 && empty1) check("pop1_when_empty", 32'(pop1), 32'(0));
    if (pop0 === 1'b1 && pop1 === 1'b1) check("double_pop", 32'(pop1), 32'(0));
    pop0_s = (pop0 === 1'b1);
    pop1_s = (pop1 === 1'b1);
    if (pop0_s && q0.size() > 0) exp_q.push_back({1'b0, q0[0]});
    if (pop1_s && q1.size() > 0) exp_q.push_back({1'b1, q1[0]});
    @(posedge clk);
    #1;
    if (pop0_s && q0.size() > 0) data_in0 = q0.pop_front();
    if (pop1_s && q1.size() > 0) data_in1 = q1.pop_front();
    empty0 = (q0.size() == 0);
    empty1 = (q1.size() == 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[7];
    int   vc[4];
    int   nv;
    int   npop;
    bit   ok;

    tbl[0] = '{1'b0, 6'h05, 5'd1, 5'd0, 1'b0};
    tbl[1] = '{1'b0, 6'h0A, 5'd2, 5'd0, 1'b0};
    tbl[2] = '{1'b1, 6'h11, 5'd2, 5'd1, 1'b0};
    tbl[3] = '{1'b1, 6'h1F, 5'd2, 5'd2, 1'b0};
    tbl[4] = '{1'b0, 6'h2F, 5'd3, 5'd2, 1'b0};
    tbl[5] = '{1'b1, 6'h03, 5'd3, 5'd3, 1'b1};
    tbl[6] = '{1'b0, 6'h10, 5'd4, 5'd3, 1'b1};

    reset = 1'b1; init = 1'b0; hold = 1'b0; active_in = 1'b0; idle_in = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_pop0", 32'(pop0), 32'(0));
    check("rst_pop1", 32'(pop1), 32'(0));
    check("rst_data", 32'(data_out), 32'(0));
    check("rst_valid", 32'(valid_out), 32'(0));
    check("rst_src", 32'(src_out), 32'(0));
    check("rst_cnt0", 32'(cnt0), 32'(0));
    check("rst_cnt1", 32'(cnt1), 32'(0));
    check("rst_err", 32'(err_out), 32'(0));
    check("rst_done", 32'(done_out), 32'(0));

    // Empty FIFOs, idle layer: done two cycles after init rises.
    tick();
    init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("done_after1", 32'(done_out), 32'(0));
    @(negedge clk);
    check("done_after2", 32'(done_out), 32'(1));
    check("done_no_pop", 32'(pop0 | pop1), 32'(0));

    // active_in pulls DONE back to RUN.
    tick();
    active_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("active_run", 32'(done_out), 32'(0));
    tick();
    active_in = 1'b0;
    repeat (3) @(negedge clk);
    check("active_redone", 32'(done_out), 32'(1));

    // D0 only: back-to-back delivery.
    tick();
    log_q.delete();
    q0.push_back(6'h05);
    q0.push_back(6'h0A);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_out && nv < 4) begin
        vc[nv] = i;
        nv++;
      end
    end
    check("d0_nvalid", 32'(nv), 32'(2));
    if (nv == 2) check("d0_b2b", 32'(vc[1] - vc[0]), 32'(1));
    check("d0_log0", 32'(log_q.size() > 0 ? log_q[0] : 6'h3F), 32'(6'h05));
    check("d0_log1", 32'(log_q.size() > 1 ? log_q[1] : 6'h3F), 32'(6'h0A));
    check("d0_cnt0", 32'(cnt0), 32'(2));
    check("d0_err", 32'(err_out), 32'(0));
    check("d0_redone", 32'(done_out), 32'(1));

    // Both FIFOs loaded before init: round robin starting at D0.
    init = 1'b0;
    do_reset();
    q0.push_back(6'h01); q0.push_back(6'h02);
    q1.push_back(6'h11); q1.push_back(6'h12);
    tick();
    tick();
    log_q.delete();
    init = 1'b1;
    repeat (12) @(negedge clk);
    check("rr_len", 32'(log_q.size()), 32'(4));
    if (log_q.size() == 4) begin
      check("rr_w0", 32'(log_q[0]), 32'(6'h01));
      check("rr_w1", 32'(log_q[1]), 32'(6'h11));
      check("rr_w2", 32'(log_q[2]), 32'(6'h02));
      check("rr_w3", 32'(log_q[3]), 32'(6'h12));
    end
    check("rr_cnt0", 32'(cnt0), 32'(2));
    check("rr_cnt1", 32'(cnt1), 32'(2));

    // Hold for three cycles mid-stream.
    n_deliv = 0;
    tick();
    for (int i = 0; i < 6; i++) q0.push_back(DW'(6'h20 + i));
    npop = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pop0) npop++;
      if (npop == 2) break;
    end
    check("hold_prepops", 32'(npop), 32'(2));
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_nopop", 32'(pop0 | pop1), 32'(0));
      if (i == 0) check("hold_inflight", 32'(valid_out), 32'(1));
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    check("hold_resume", 32'(pop0), 32'(1));
    repeat (15) @(negedge clk);
    check("hold_total", 32'(n_deliv), 32'(6));
    check("hold_cnt0", 32'(cnt0), 32'(8));
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    // Single-word table: counts and sticky error flag.
    init = 1'b0;
    do_reset();
    init = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (tbl[i].sel) q1.push_back(tbl[i].data);
      else q0.push_back(tbl[i].data);
      ok = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (valid_out) begin
          ok = 1'b1;
          break;
        end
      end
      check("tbl_deliv", 32'(ok), 32'(1));
      check("tbl_data", 32'(data_out), 32'(tbl[i].data));
      check("tbl_src", 32'(src_out), 32'(tbl[i].sel));
      @(negedge clk);
      check("tbl_cnt0", 32'(cnt0), 32'(tbl[i].c0));
      check("tbl_cnt1", 32'(cnt1), 32'(tbl[i].c1));
      check("tbl_err", 32'(err_out), 32'(tbl[i].err));
    end
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err_out), 32'(1));

    // 40 words into D0: counter saturates at 31.
    init = 1'b0;
    do_reset();
    init = 1'b1;
    n_deliv = 0;
    for (int i = 0; i < 40; i++) q0.push_back(DW'(6'h20 | (i & 15)));
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (n_deliv >= 40) break;
    end
    check("sat_deliv", 32'(n_deliv), 32'(40));
    @(negedge clk);
    check("sat_cnt0", 32'(cnt0), 32'(31));
    check("sat_cnt1", 32'(cnt1), 32'(0));

    // Reset with a pop in flight: the word is discarded.
    tick();
    for (int i = 0; i < 3; i++) q0.push_back(DW'(6'h21 + i));
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pop0) begin
        ok = 1'b1;
        break;
      end
    end
    check("rr_inflight_pop", 32'(ok), 32'(1));
    #1;
    reset = 1'b1;
    init = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", 32'(valid_out), 32'(0));
    check("mid_rst_data", 32'(data_out), 32'(0));
    check("mid_rst_src", 32'(src_out), 32'(0));
    check("mid_rst_cnt0", 32'(cnt0), 32'(0));
    check("mid_rst_err", 32'(err_out), 32'(0));
    check("mid_rst_done", 32'(done_out), 32'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_quiet", 32'(valid_out | pop0 | pop1), 32'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
